// File: rtl/ex_muldiv_unit_pkg.sv
// Shared op codes, state codes and default latencies for the EX multiply/divide unit.
// The ID decoder and the hazard unit import the same package.
package ex_muldiv_unit_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   localparam int DEFAULT_MULT_CYCLES = 5;
   localparam int DEFAULT_DIV_CYCLES  = 10;
   localparam int DEFAULT_CNT_W       = 4;

   // Codes 0..3 start a multi-cycle operation.
   function automatic logic md_is_arith(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_signed(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO. The result is computed at start
// into a shadow pair and committed when the latency counter expires.
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES,
   parameter int CNT_W       = DEFAULT_CNT_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       hi_n_q, hi_n_d;
   logic [31:0]       lo_n_q, lo_n_d;
   logic              wr_q, wr_d;

   logic              op_signed;
   logic [63:0]       mul_a, mul_b, mul_p;
   logic [32:0]       div_a, div_b, div_b_safe;
   logic              div_b_nz;
   logic signed [32:0] div_q, div_r;
   logic              unused_div_msb;

   // Sign/zero extension makes one 64-bit multiply and one 33-bit signed divide
   // serve both signed and unsigned forms; 33 bits also holds 0x80000000 / -1.
   always_comb begin
      op_signed  = md_is_signed(md_op);
      mul_a      = op_signed ? {{32{rs_val[31]}}, rs_val} : {32'b0, rs_val};
      mul_b      = op_signed ? {{32{rt_val[31]}}, rt_val} : {32'b0, rt_val};
      mul_p      = mul_a * mul_b;
      div_a      = {op_signed & rs_val[31], rs_val};
      div_b      = {op_signed & rt_val[31], rt_val};
      div_b_nz   = (rt_val != 32'b0);
      div_b_safe = div_b_nz ? div_b : 33'd1;
      div_q      = $signed(div_a) / $signed(div_b_safe);
      div_r      = $signed(div_a) % $signed(div_b_safe);
   end

   assign unused_div_msb = div_q[32] ^ div_r[32];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      hi_n_d  = hi_n_q;
      lo_n_d  = lo_n_q;
      wr_d    = wr_q;
      case (state_q)
         MD_IDLE: begin
            if (start) begin
               if (md_is_arith(md_op)) begin
                  state_d = MD_RUN;
                  busy_d  = 1'b1;
                  if (md_is_div(md_op)) begin
                     cnt_d  = CNT_W'(DIV_CYCLES);
                     hi_n_d = div_r[31:0];
                     lo_n_d = div_q[31:0];
                     wr_d   = div_b_nz;
                  end else begin
                     cnt_d  = CNT_W'(MULT_CYCLES);
                     hi_n_d = mul_p[63:32];
                     lo_n_d = mul_p[31:0];
                     wr_d   = 1'b1;
                  end
               end else if (md_op == MD_MTHI) begin
                  hi_d = rs_val;
               end else if (md_op == MD_MTLO) begin
                  lo_d = rs_val;
               end
            end
         end
         MD_RUN: begin
            // start is ignored here; the hazard unit stalls on busy | start.
            if (cnt_q == CNT_W'(1)) begin
               state_d = MD_IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
               if (wr_q) begin
                  hi_d = hi_n_q;
                  lo_d = lo_n_q;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = MD_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         hi_n_q  <= '0;
         lo_n_q  <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         hi_n_q  <= hi_n_d;
         lo_n_q  <= lo_n_d;
         wr_q    <= wr_d;
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: latency, HI/LO results, MTHI/MTLO, divide by zero,
// reset during an operation and an illegal start while busy.
module tb_ex_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks;
   int n_pass;
   int n_illegal;

   ex_muldiv_unit #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10),
      .CNT_W      (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .rs_val(rs_val),
      .rt_val(rt_val),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flags a start that arrives while an operation is in flight.
   always @(posedge clk) begin
      if (!reset && start && busy) begin
         n_illegal = n_illegal + 1;
         $display("note: start while busy at %0t (op %0d)", $time, md_op);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (obs === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // One-cycle op pulse; returns at the negedge after the capturing edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start  = 1'b1;
      md_op  = op;
      rs_val = a;
      rt_val = b;
      @(negedge clk);
      start  = 1'b0;
      md_op  = 3'd7;
   endtask

   // Issues an arithmetic op, counts busy cycles, then checks HI/LO.
   // inject_at > 0 drives an illegal DIVU 100/7 start on that busy cycle.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int ncyc, input logic [31:0] ehi,
                         input logic [31:0] elo, input int inject_at);
      int cnt;
      issue(op, a, b);
      cnt = 0;
      while (busy === 1'b1 && cnt < 50) begin
         cnt = cnt + 1;
         if (cnt == inject_at) begin
            start  = 1'b1;
            md_op  = 3'd3;
            rs_val = 32'd100;
            rt_val = 32'd7;
         end else begin
            start  = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, " busy_cycles"}, 32'(cnt), 32'(ncyc));
      check({tag, " hi"}, hi, ehi);
      check({tag, " lo"}, lo, elo);
      @(negedge clk);
      check({tag, " busy_after"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int cnt;
      n_checks  = 0;
      n_pass    = 0;
      n_illegal = 0;
      reset  = 1'b1;
      start  = 1'b0;
      md_op  = 3'd7;
      rs_val = '0;
      rt_val = '0;
      repeat (3) @(negedge clk);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset hi", hi, 32'h0);
      check("reset lo", lo, 32'h0);
      reset = 1'b0;

      run_op("mult", 3'd0, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
      run_op("multu", 3'd1, 32'hFFFFFFFD, 32'd5, 5, 32'h00000004, 32'hFFFFFFF1, 0);
      run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
      run_op("divu", 3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3, 0);
      run_op("div_negdivisor", 3'd2, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD, 0);
      run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000, 0);
      run_op("divu_big", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h80000000, 32'h0, 0);

      // MTHI / MTLO preload, visible at once with busy low
      issue(3'd4, 32'h11, 32'hDEAD);
      check("mthi hi", hi, 32'h11);
      check("mthi busy", {31'b0, busy}, 32'd0);
      issue(3'd5, 32'h22, 32'hBEEF);
      check("mtlo lo", lo, 32'h22);
      check("mtlo hi_kept", hi, 32'h11);
      check("mtlo busy", {31'b0, busy}, 32'd0);

      // reserved op has no effect
      issue(3'd6, 32'h55, 32'h66);
      check("rsvd busy", {31'b0, busy}, 32'd0);
      check("rsvd hi", hi, 32'h11);
      check("rsvd lo", lo, 32'h22);

      run_op("div0", 3'd2, 32'd9, 32'd0, 10, 32'h11, 32'h22, 0);

      // reset on the third busy cycle drops the result
      issue(3'd0, 32'd3, 32'd4);
      cnt = 1;
      while (cnt < 3 && busy === 1'b1) begin
         @(negedge clk);
         cnt = cnt + 1;
      end
      check("rst_mid busy_before", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid busy", {31'b0, busy}, 32'd0);
      check("rst_mid hi", hi, 32'h0);
      check("rst_mid lo", lo, 32'h0);
      repeat (8) @(negedge clk);
      check("rst_mid no_late_hi", hi, 32'h0);
      check("rst_mid no_late_lo", lo, 32'h0);
      check("rst_mid no_late_busy", {31'b0, busy}, 32'd0);

      // illegal start on busy cycle 2 is ignored
      run_op("mult_ignore", 3'd0, 32'd2, 32'd3, 5, 32'h0, 32'd6, 2);
      check("illegal_start_flagged", 32'(n_illegal), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
